// File: rtl/fifo_sync_param_pkg.sv
// Shared types for the parametrised synchronous FIFO.
// Provides the per-cycle operation encoding used by the occupancy logic.
package fifo_sync_param_pkg;

  // Accepted operation in one cycle: {push, pop}
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Fold the accepted push/pop qualifiers into one operation code
  function automatic fifo_op_e fifo_op(input logic push, input logic pop);
    return fifo_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// Storage array for fifo_sync_param: WIDTH x DEPTH, one synchronous write
// port and one combinational read port.
// Ports:
//   clk          clock, write on posedge
//   we/waddr/wdata  write enable, index, data
//   raddr/rdata     read index and asynchronous read data
module fifo_sync_ram #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with registered occupancy count, flags
// decoded from that count, error pulses and a standard or FWFT read port.
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   wr_en, wr_data             write request and data
//   rd_en                      read request (pop / acknowledge in FWFT)
//   rd_data, rd_valid          read data and its qualifier
//   full, empty                count == DEPTH / count == 0
//   almost_full, almost_empty  count >= AF_THRESH / count <= AE_THRESH
//   count                      occupancy 0..DEPTH
//   overflow, underflow        one-cycle pulses for rejected requests
module fifo_sync_param
  import fifo_sync_param_pkg::*;
#(
  parameter  int unsigned WIDTH     = 8,
  parameter  int unsigned DEPTH     = 16,
  parameter  int unsigned AF_THRESH = DEPTH - 2,
  parameter  int unsigned AE_THRESH = 2,
  parameter  bit          FWFT      = 1'b0,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned CW = AW + 1;

  logic [AW:0]      wr_ptr_q, rd_ptr_q, count_q, count_nxt;
  logic             rd_ok, wr_ok;
  fifo_op_e         op;
  logic             empty_q, full_q, af_q, ae_q, ovf_q, udf_q;
  logic [WIDTH-1:0] ram_rdata;

  // Request qualification; a full FIFO still accepts a write alongside a pop
  always_comb begin
    rd_ok     = rd_en && !empty_q;
    wr_ok     = wr_en && (!full_q || rd_ok);
    op        = fifo_op(wr_ok, rd_ok);
    count_nxt = count_q;
    case (op)
      OP_PUSH: count_nxt = count_q + CW'(1);
      OP_POP:  count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase
  end

  // Pointers, occupancy, flags (registered from next count) and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      af_q     <= (AF_THRESH == 0);
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + CW'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + CW'(1);
      count_q <= count_nxt;
      empty_q <= (count_nxt == CW'(0));
      full_q  <= (count_nxt == CW'(DEPTH));
      af_q    <= (count_nxt >= CW'(AF_THRESH));
      ae_q    <= (count_nxt <= CW'(AE_THRESH));
      ovf_q   <= wr_en && !wr_ok;
      udf_q   <= rd_en && !rd_ok;
    end
  end

  fifo_sync_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (ram_rdata)
  );

  // Read port: FWFT shows the head word directly, standard registers it on pop
  if (FWFT) begin : g_fwft
    assign rd_data  = ram_rdata;
    assign rd_valid = !empty_q;
  end else begin : g_std
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_ok;
        if (rd_ok) rd_data_q <= ram_rdata;
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench: a standard-mode and an FWFT-mode FIFO (DEPTH=4),
// each compared against a queue scoreboard.
module tb_fifo_sync_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Standard-mode instance
  logic       s_wr_en, s_rd_en;
  logic [7:0] s_wr_data, s_rd_data;
  logic       s_rd_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic [2:0] s_count;

  // FWFT instance
  logic       f_wr_en, f_rd_en;
  logic [7:0] f_wr_data, f_rd_data;
  logic       f_rd_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [2:0] f_count;

  fifo_sync_param #(.WIDTH(8), .DEPTH(4), .AF_THRESH(2), .AE_THRESH(2), .FWFT(1'b0)) u_std (
    .clk(clk), .rst(rst), .wr_en(s_wr_en), .wr_data(s_wr_data), .rd_en(s_rd_en),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_udf)
  );

  fifo_sync_param #(.WIDTH(8), .DEPTH(4), .AF_THRESH(2), .AE_THRESH(2), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_udf)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sb_s [$];
  logic [7:0] sb_f [$];
  logic [7:0] last_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One cycle on the standard FIFO; expectations come from the queue model
  task automatic s_step(input logic w, input logic [7:0] d, input logic r);
    logic       rdok, wrok;
    logic [7:0] expd;
    int         sz;
    sz   = sb_s.size();
    rdok = r && (sz != 0);
    wrok = w && ((sz < 4) || rdok);
    expd = last_rd;
    if (rdok) expd = sb_s.pop_front();
    if (wrok) sb_s.push_back(d);
    s_wr_en = w; s_wr_data = d; s_rd_en = r;
    @(posedge clk); #1;
    s_wr_en = 1'b0; s_rd_en = 1'b0;
    last_rd = expd;
    sz = sb_s.size();
    check("s_rd_valid",  32'(s_rd_valid), 32'(rdok));
    check("s_rd_data",   32'(s_rd_data),  32'(expd));
    check("s_count",     32'(s_count),    32'(sz));
    check("s_full",      32'(s_full),     32'(sz == 4));
    check("s_empty",     32'(s_empty),    32'(sz == 0));
    check("s_af",        32'(s_af),       32'(sz >= 2));
    check("s_ae",        32'(s_ae),       32'(sz <= 2));
    check("s_overflow",  32'(s_ovf),      32'(w && !wrok));
    check("s_underflow", 32'(s_udf),      32'(r && !rdok));
  endtask

  // One cycle on the FWFT FIFO
  task automatic f_step(input logic w, input logic [7:0] d, input logic r);
    logic rdok, wrok;
    int   sz;
    sz   = sb_f.size();
    rdok = r && (sz != 0);
    wrok = w && ((sz < 4) || rdok);
    if (rdok) void'(sb_f.pop_front());
    if (wrok) sb_f.push_back(d);
    f_wr_en = w; f_wr_data = d; f_rd_en = r;
    @(posedge clk); #1;
    f_wr_en = 1'b0; f_rd_en = 1'b0;
    sz = sb_f.size();
    check("f_rd_valid",  32'(f_rd_valid), 32'(sz != 0));
    if (sz != 0) check("f_rd_data", 32'(f_rd_data), 32'(sb_f[0]));
    check("f_count",     32'(f_count),    32'(sz));
    check("f_overflow",  32'(f_ovf),      32'(w && !wrok));
    check("f_underflow", 32'(f_udf),      32'(r && !rdok));
  endtask

  // Reset cycle with a write request that must be ignored
  task automatic s_reset();
    rst = 1'b1; s_wr_en = 1'b1; s_wr_data = 8'hEE;
    @(posedge clk); #1;
    rst = 1'b0; s_wr_en = 1'b0;
    sb_s.delete();
    last_rd = 8'h00;
    check("rst_count",    32'(s_count),    32'd0);
    check("rst_empty",    32'(s_empty),    32'd1);
    check("rst_full",     32'(s_full),     32'd0);
    check("rst_ae",       32'(s_ae),       32'd1);
    check("rst_af",       32'(s_af),       32'd0);
    check("rst_rd_valid", 32'(s_rd_valid), 32'd0);
    check("rst_rd_data",  32'(s_rd_data),  32'd0);
    check("rst_overflow", 32'(s_ovf),      32'd0);
  endtask

  initial begin
    rst = 1'b1;
    s_wr_en = 1'b0; s_rd_en = 1'b0; s_wr_data = 8'h00;
    f_wr_en = 1'b0; f_rd_en = 1'b0; f_wr_data = 8'h00;
    last_rd = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("init_s_count", 32'(s_count),    32'd0);
    check("init_s_empty", 32'(s_empty),    32'd1);
    check("init_s_ae",    32'(s_ae),       32'd1);
    check("init_s_af",    32'(s_af),       32'd0);
    check("init_s_valid", 32'(s_rd_valid), 32'd0);
    check("init_s_data",  32'(s_rd_data),  32'd0);
    check("init_f_valid", 32'(f_rd_valid), 32'd0);
    check("init_f_empty", 32'(f_empty),    32'd1);

    // Fill, then overflow on a 5th write
    for (int i = 0; i < 4; i++) s_step(1'b1, 8'hA1 + 8'(i), 1'b0);
    s_step(1'b1, 8'hA5, 1'b0);
    check("fill_count_4", 32'(s_count), 32'd4);

    // Drain, then underflow on a 5th read
    for (int i = 0; i < 5; i++) s_step(1'b0, 8'h00, 1'b1);

    // Full with simultaneous read and write
    for (int i = 0; i < 4; i++) s_step(1'b1, 8'hA1 + 8'(i), 1'b0);
    s_step(1'b1, 8'hB5, 1'b1);
    check("full_rw_data", 32'(s_rd_data), 32'hA1);
    for (int i = 0; i < 4; i++) s_step(1'b0, 8'h00, 1'b1);
    check("drain_last_b5", 32'(s_rd_data), 32'hB5);

    // Empty with simultaneous read and write: write only
    s_step(1'b1, 8'hC1, 1'b1);
    s_step(1'b0, 8'h00, 1'b1);
    check("empty_rw_c1", 32'(s_rd_data), 32'hC1);

    // Continuous traffic across pointer wrap
    s_step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 12; i++) s_step(1'b1, 8'($urandom_range(0, 255)), 1'b1);
    s_step(1'b0, 8'h00, 1'b1);

    // Reset with three entries stored
    for (int i = 0; i < 3; i++) s_step(1'b1, 8'h30 + 8'(i), 1'b0);
    s_reset();
    s_step(1'b1, 8'hD1, 1'b0);
    s_step(1'b0, 8'h00, 1'b1);
    check("post_rst_d1", 32'(s_rd_data), 32'hD1);

    // FWFT: word visible without rd_en, pop empties
    f_step(1'b1, 8'h11, 1'b0);
    check("fwft_11", 32'(f_rd_data), 32'h11);
    f_step(1'b0, 8'h00, 1'b1);
    f_step(1'b1, 8'h22, 1'b0);
    f_step(1'b1, 8'h33, 1'b0);
    f_step(1'b0, 8'h00, 1'b1);
    check("fwft_next_33", 32'(f_rd_data), 32'h33);
    f_step(1'b0, 8'h00, 1'b1);
    f_step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) f_step(1'b1, 8'h40 + 8'(i), 1'b0);
    f_step(1'b1, 8'h50, 1'b1);
    for (int i = 0; i < 4; i++) f_step(1'b0, 8'h00, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
